// File: rtl/uart_echo_engine.sv
// uart_echo_engine: buffers received bytes in a FIFO and echoes each one to a
// character transmitter as raw, uppercased, hex or hex+space text. It also
// keeps overflow/drop and transmitted-character statistics.
module uart_echo_engine #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [7:0]               i_rx_byte,
    input  logic                     i_rx_valid,
    input  logic [1:0]               i_mode,
    input  logic                     i_tx_active,
    input  logic                     i_tx_done,
    output logic [7:0]               o_tx_byte,
    output logic                     o_tx_dv,
    output logic [7:0]               o_last_byte,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_fifo_full,
    output logic                     o_overflow,
    output logic [CNT_W-1:0]         o_drop_count,
    output logic [CNT_W-1:0]         o_tx_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    // ASCII uppercase hex digit for one nibble
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            hex_char = 8'h30 + {4'h0, n};
        end else begin
            hex_char = 8'h37 + {4'h0, n};
        end
    endfunction

    // Character number idx of byte b rendered in mode m
    function automatic logic [7:0] char_of(input logic [7:0] b,
                                           input logic [1:0] m,
                                           input logic [1:0] idx);
        case (m)
            2'd0: char_of = b;
            2'd1: char_of = (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
            default: begin
                case (idx)
                    2'd0:    char_of = hex_char(b[7:4]);
                    2'd1:    char_of = hex_char(b[3:0]);
                    default: char_of = 8'h20;
                endcase
            end
        endcase
    endfunction

    // Index of the final character a byte produces in mode m
    function automatic logic [1:0] last_idx(input logic [1:0] m);
        case (m)
            2'd2:    last_idx = 2'd1;
            2'd3:    last_idx = 2'd2;
            default: last_idx = 2'd0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [7:0]       byte_q, byte_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       last_byte_q;
    logic             overflow_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] tx_cnt_q;

    logic             pop;
    logic             push;
    logic             drop;
    logic             tx_dv;
    logic             tx_inc;

    // A full FIFO still accepts a byte when the head leaves on the same edge
    assign push = i_rx_valid && ((count_q != FULL_CNT) || pop);
    assign drop = i_rx_valid && !push;

    // Echo sequencer: pop a byte, then hand its characters out one at a time
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;
        tx_dv     = 1'b0;
        tx_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !i_tx_active) begin
                    pop       = 1'b1;
                    byte_d    = mem_q[rd_ptr_q];
                    mode_d    = i_mode;
                    idx_d     = 2'd0;
                    tx_byte_d = char_of(mem_q[rd_ptr_q], i_mode, 2'd0);
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                tx_dv   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    tx_inc = 1'b1;
                    if (idx_q != last_idx(mode_q)) begin
                        idx_d     = idx_q + 2'd1;
                        tx_byte_d = char_of(byte_q, mode_q, idx_q + 2'd1);
                        state_d   = S_SEND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and the latched byte/mode/character being sent
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            byte_q    <= '0;
            mode_q    <= '0;
            idx_q     <= '0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    // FIFO storage; contents need no reset since the count gates every read
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_rx_byte;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Receive-side statistics: last byte seen, sticky overflow, drop count
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_byte_q <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            if (i_rx_valid) begin
                last_byte_q <= i_rx_byte;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end
        end
    end

    // Completed-character counter, wrapping
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_cnt_q <= '0;
        end else if (tx_inc) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
        end
    end

    assign o_tx_byte    = tx_byte_q;
    assign o_tx_dv      = tx_dv;
    assign o_last_byte  = last_byte_q;
    assign o_fifo_count = count_q;
    assign o_fifo_full  = (count_q == FULL_CNT);
    assign o_overflow   = overflow_q;
    assign o_drop_count = drop_cnt_q;
    assign o_tx_count   = tx_cnt_q;

endmodule

// File: doc/uart_echo_engine.md
UART_ECHO_ENGINE -- requirements
Module: uart_echo_engine

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: i_clk and i_reset.
REQ-002 Parameter DEPTH SHALL default to 16 and set the FIFO depth in bytes; legal values are powers of 2 that are at least 2.
REQ-003 Parameter CNT_W SHALL default to 16 and set the width of the statistics counters.
REQ-004 Ports SHALL be, clock and reset first:
- i_clk  in  1  system clock.
- i_reset  in  1  async active-high reset.
- i_rx_byte  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe qualifying i_rx_byte.
- i_mode  in  2  output format: 0 raw, 1 uppercase, 2 hex, 3 hex+space.
- i_tx_active  in  1  transmitter busy.
- i_tx_done  in  1  one-cycle strobe at end of a transmitted character.
- o_tx_byte  out  8  character to transmit.
- o_tx_dv  out  1  one-cycle start strobe to the transmitter.
- o_last_byte  out  8  most recent received byte.
- o_fifo_count  out  clog2(DEPTH)+1  bytes currently held in the FIFO.
- o_fifo_full  out  1  high when o_fifo_count equals DEPTH.
- o_overflow  out  1  sticky flag, set when a byte is dropped.
- o_drop_count  out  CNT_W  number of dropped bytes, saturating.
- o_tx_count  out  CNT_W  number of characters completed, wrapping.

Function
REQ-005 The FIFO write SHALL occur on an edge where i_rx_valid=1 and either o_fifo_count<DEPTH or a pop occurs on the same edge.
REQ-006 When i_rx_valid=1, the FIFO is full and there is no same-edge pop, the byte SHALL be dropped: o_overflow goes to 1 and o_drop_count increments, saturating at all ones.
REQ-007 o_fifo_count SHALL change by +1 on a push only, by -1 on a pop only, and SHALL be unchanged on a simultaneous push and pop.
REQ-008 FIFO read and write pointers SHALL wrap modulo DEPTH without any gap or duplicate.
REQ-009 o_last_byte SHALL load i_rx_byte on every i_rx_valid, including dropped bytes.
REQ-010 The FSM SHALL have three states: S_IDLE, S_SEND and S_WAIT.
REQ-011 In S_IDLE, when the FIFO is not empty and i_tx_active=0, the FSM SHALL pop the head byte, latch that byte together with i_mode, clear the character index and go to S_SEND.
REQ-012 In S_SEND, o_tx_dv SHALL be 1 for exactly that cycle, o_tx_byte SHALL carry the indexed character, and the FSM SHALL go to S_WAIT.
REQ-013 In S_WAIT, o_tx_dv SHALL be 0 and i_tx_active SHALL be ignored.
REQ-014 In S_WAIT, on i_tx_done the FSM SHALL increment o_tx_count and then:
- go to S_SEND with the index incremented if more characters remain;
- otherwise go to S_IDLE.
REQ-015 o_tx_byte SHALL remain stable from S_SEND through the end of S_WAIT.
REQ-016 Characters per byte SHALL follow the latched mode:
- Mode 0: 1 character, the byte unchanged.
- Mode 1: 1 character; bytes 0x61-0x7A become byte-0x20, all other bytes unchanged.
- Mode 2: 2 characters, the ASCII uppercase hex of the high nibble then the low nibble (0-9 map to 0x30-0x39, A-F map to 0x41-0x46).
- Mode 3: 3 characters, the mode-2 pair followed by 0x20.
REQ-017 A change of i_mode SHALL affect only bytes popped after the change, never a byte in progress.
REQ-018 Latency: a byte pushed at edge T into an empty FIFO, with the FSM in S_IDLE and i_tx_active=0, SHALL be popped at edge T+1, and o_tx_dv SHALL be high in the cycle following edge T+1.
REQ-019 While i_tx_active=1, the FSM SHALL remain in S_IDLE and the FIFO SHALL retain its contents.

Reset
REQ-020 Asserting i_reset SHALL immediately, with no clock required, force the following outputs and state:
- FSM to S_IDLE;
- FIFO pointers and o_fifo_count to 0;
- o_tx_dv, o_tx_byte, o_last_byte, o_fifo_full, o_overflow, o_drop_count and o_tx_count to 0.
REQ-021 Reset asserted mid-character SHALL abandon the character; after release the engine SHALL not emit o_tx_dv until a new byte is pushed.
REQ-022 o_overflow SHALL be cleared only by i_reset.

Verification
REQ-023 Mode 0: push 0x41 with i_tx_done returned 10 cycles after o_tx_dv -> one o_tx_dv carrying 0x41, two cycles after the push; o_tx_count=1.
REQ-024 Mode 1, push 0x61,0x7B,0x5A -> transmitted 0x41,0x7B,0x5A in order.
REQ-025 Modes 2 and 3, push 0x3C -> mode 2 sends 0x33,0x43; mode 3 sends 0x33,0x43,0x20; o_tx_count increments once per character.
REQ-026 Hold i_tx_active=1 and push DEPTH+3 bytes -> o_fifo_full=1, o_overflow=1, o_drop_count=3, o_last_byte equals the final byte; after releasing i_tx_active, exactly DEPTH bytes are echoed in order.
REQ-027 With the FIFO full and a pop and a push on the same edge -> the push is accepted, o_fifo_count stays at DEPTH and o_drop_count is unchanged.
REQ-028 Assert i_reset during S_WAIT of a mode-2 byte with the FIFO holding 2 bytes -> all outputs go to 0 at once, and no o_tx_dv occurs after release until a new push.
